// File: rtl/final_project_soc_pio_pkg.sv
// Shared constants and elaboration range checks for the SoC input PIO family.
// Register word addresses, edge-type selectors and parameter validators.
package final_project_soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= 32);
  endfunction

  function automatic bit stages_ok(input int s);
    return (s >= 2) && (s <= 4);
  endfunction

  function automatic bit edge_type_ok(input int e);
    return (e == EDGE_RISE) || (e == EDGE_FALL) || (e == EDGE_ANY);
  endfunction

endpackage

// File: rtl/final_project_soc_sync_chain.sv
// Multi-stage flop chain that brings asynchronous pins into the clk domain.
// All stages clear asynchronously; q is the last stage.
module final_project_soc_sync_chain #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/final_project_soc_pio_in_capture.sv
// Avalon-MM input PIO: synchronised pins, edge detect, W1C edge capture,
// maskable level irq and a registered, side-effect-free read port.
module final_project_soc_pio_in_capture
  import final_project_soc_pio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("WIDTH must be in 1..32");
  end
  if (!stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (!edge_type_ok(EDGE_TYPE)) begin : g_bad_edge
    $error("EDGE_TYPE must be 0, 1 or 2");
  end

  // Priming lasts until prev holds a real synchronised sample, so pins that
  // are already asserted at reset release never look like an edge.
  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int CW        = $clog2(PRIME_MAX + 1);

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clear_bits;
  logic [CW-1:0]    prime_cnt;
  logic             primed;
  logic             wr_en;
  logic [31:0]      rd_next;

  final_project_soc_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_out)
  );

  assign primed = (prime_cnt == CW'(PRIME_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= '0;
      prev      <= '0;
    end else begin
      if (!primed) prime_cnt <= prime_cnt + CW'(1);
      prev <= sync_out;
    end
  end

  always_comb begin
    edge_hit = '0;
    if (primed) begin
      case (EDGE_TYPE)
        EDGE_FALL: edge_hit = ~sync_out & prev;
        EDGE_ANY:  edge_hit = sync_out ^ prev;
        default:   edge_hit = sync_out & ~prev;
      endcase
    end
  end

  // Bus: a write is accepted on every clk edge where chipselect is high and
  // write_n low; there is no wait state. Reads have no strobe: readdata
  // always shows the register addressed on the previous cycle.
  assign wr_en      = chipselect && !write_n;
  assign clear_bits = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
      // A new edge in the same cycle as its clear keeps the bit set.
      edge_capture <= (edge_capture & ~clear_bits) | edge_hit;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = sync_out;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_final_project_soc_pio_in_capture.sv
// Directed bench for the input-capture PIO: four instances cover rising,
// falling and any-edge detection plus the 32-bit, 4-stage configuration.
module tb_final_project_soc_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;

  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  final_project_soc_pio_in_capture #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[15:0]),
    .readdata(rd0), .irq(irq0));

  final_project_soc_pio_in_capture #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[15:0]),
    .readdata(rd1), .irq(irq1));

  final_project_soc_pio_in_capture #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[15:0]),
    .readdata(rd2), .irq(irq2));

  final_project_soc_pio_in_capture #(.WIDTH(32), .SYNC_STAGES(4), .EDGE_TYPE(0)) dut_wide (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd3), .irq(irq3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic do_reset(input logic [31:0] pins);
    reset_n = 1'b0;
    in_port = pins;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 32'h0000_FFFF;
    tick();
    tick();
    check("reset_readdata", rd0, 32'h0);
    check("reset_irq", {31'b0, irq0}, 32'h0);
    check("reset_readdata_wide", rd3, 32'h0);

    // Pins high through reset: DATA follows, no capture ever appears.
    reset_n = 1'b1;
    address = 2'd0;
    repeat (4) tick();
    check("data_after_release", rd0, 32'h0000_FFFF);
    address = 2'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("prime_no_capture_%0d", i), rd0, 32'h0);
    end
    wr(2'd2, 32'h0000_FFFF);
    check("prime_irq_low", {31'b0, irq0}, 32'h0);

    // Rising edges on bits 0 and 2, only bit 0 unmasked.
    do_reset(32'h0);
    repeat (6) tick();
    wr(2'd2, 32'h1);
    in_port = 32'h5;
    tick();
    tick();
    check("irq_before_capture", {31'b0, irq0}, 32'h0);
    tick();
    check("irq_at_capture", {31'b0, irq0}, 32'h1);
    rd(2'd3);
    check("capture_5", rd0, 32'h5);
    rd(2'd0);
    check("data_5", rd0, 32'h5);

    // W1C of bit 0 drops irq at once; unmasking bit 2 raises it.
    wr(2'd3, 32'h1);
    check("irq_after_clear", {31'b0, irq0}, 32'h0);
    rd(2'd3);
    check("capture_after_clear", rd0, 32'h4);
    wr(2'd2, 32'h4);
    check("irq_after_mask", {31'b0, irq0}, 32'h1);
    rd(2'd2);
    check("mask_readback", rd0, 32'h4);

    // Bit 3 rises on the very edge that clears it.
    in_port = 32'hD;
    tick();
    tick();
    wr(2'd3, 32'h8);
    check("irq_edge_vs_clear", {31'b0, irq0}, 32'h1);
    rd(2'd3);
    check("edge_wins_clear", rd0, 32'hC);
    wr(2'd3, 32'h8);
    rd(2'd3);
    check("plain_clear_bit3", rd0, 32'h4);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd2);
    check("data_write_ignored", rd0, 32'h4);
    rd(2'd1);
    check("reserved_reads_0", rd0, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    check("irq_after_clear_all", {31'b0, irq0}, 32'h0);
    rd(2'd3);
    check("capture_cleared", rd0, 32'h0);

    // Falling-only versus any-edge on bit 0.
    do_reset(32'h0);
    repeat (6) tick();
    in_port = 32'h1;
    repeat (4) tick();
    rd(2'd3);
    check("fall_ignores_rise", rd1, 32'h0);
    check("any_sees_rise", rd2, 32'h1);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0;
    repeat (4) tick();
    rd(2'd3);
    check("fall_sees_fall", rd1, 32'h1);
    check("any_sees_fall", rd2, 32'h1);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h1;
    repeat (4) tick();
    rd(2'd3);
    check("fall_ignores_rise2", rd1, 32'h0);
    check("any_sees_rise2", rd2, 32'h1);

    // Mid-stream reset clears everything immediately and re-primes.
    do_reset(32'h0);
    repeat (6) tick();
    wr(2'd2, 32'h0000_FFFF);
    in_port = 32'hFF;
    repeat (4) tick();
    rd(2'd3);
    check("capture_ff", rd0, 32'hFF);
    check("irq_before_reset", {31'b0, irq0}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", {31'b0, irq0}, 32'h0);
    check("async_reset_readdata", rd0, 32'h0);
    tick();
    reset_n = 1'b1;
    address = 2'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("reprime_no_capture_%0d", i), rd0, 32'h0);
    end
    rd(2'd2);
    check("mask_after_reset", rd0, 32'h0);
    wr(2'd2, 32'h0000_FFFF);
    check("irq_after_reprime", {31'b0, irq0}, 32'h0);

    // 32-bit, 4-stage instance: capture two cycles later than the default.
    do_reset(32'h0);
    repeat (8) tick();
    wr(2'd2, 32'h1);
    in_port = 32'h5;
    repeat (4) tick();
    check("wide_irq_before_capture", {31'b0, irq3}, 32'h0);
    tick();
    check("wide_irq_at_capture", {31'b0, irq3}, 32'h1);
    rd(2'd3);
    check("wide_capture_5", rd3, 32'h5);
    in_port = 32'h8000_0005;
    repeat (6) tick();
    rd(2'd3);
    check("wide_capture_msb", rd3, 32'h8000_0005);
    rd(2'd0);
    check("wide_data_msb", rd3, 32'h8000_0005);
    check("narrow_data_zero_ext", rd0, 32'h0000_0005);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
